// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcodes, vector payload, sweep states and the reference model.
package alu_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned OPW   = 3;
    localparam int unsigned NOPS  = 8;
    localparam int unsigned ERRW  = 12;

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR = OPW'(7);

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE
    } sweep_state_e;

    // Golden 5-bit ALU result.
    function automatic logic [WIDTH:0] alu_model(input logic [OPW-1:0]   op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        alu_model = '0;
        case (op)
            OP_ADD:  alu_model = {1'b0, a} + {1'b0, b};
            OP_SUB:  alu_model = {1'b0, a} - {1'b0, b};
            OP_AND:  alu_model = {1'b0, a & b};
            OP_OR:   alu_model = {1'b0, a | b};
            OP_XOR:  alu_model = {1'b0, a ^ b};
            OP_NOT:  alu_model = {1'b0, ~a};
            OP_SHL:  alu_model = {a, 1'b0};
            OP_SHR:  alu_model = {2'b00, a[WIDTH-1:1]};
            default: alu_model = '0;
        endcase
    endfunction

    // Lowest enabled opcode; 0 for an empty mask.
    function automatic logic [OPW-1:0] first_op(input logic [NOPS-1:0] mask);
        first_op = '0;
        for (int i = NOPS - 1; i >= 0; i--) begin
            if (mask[i]) first_op = OPW'(i);
        end
    endfunction

    // Lowest enabled opcode strictly above op; op itself when none remains.
    function automatic logic [OPW-1:0] next_op(input logic [NOPS-1:0] mask,
                                               input logic [OPW-1:0]  op);
        next_op = op;
        for (int i = NOPS - 1; i >= 0; i--) begin
            if (mask[i] && (OPW'(i) > op)) next_op = OPW'(i);
        end
    endfunction

    function automatic logic has_next(input logic [NOPS-1:0] mask,
                                      input logic [OPW-1:0]  op);
        has_next = 1'b0;
        for (int i = 0; i < NOPS; i++) begin
            if (mask[i] && (OPW'(i) > op)) has_next = 1'b1;
        end
    endfunction

endpackage

// File: rtl/alu_sweep_checker_if.sv
// Operand/result bus between the sweep checker and the ALU under test.
interface alu_sweep_checker_if;
    logic [alu_pkg::WIDTH-1:0] alu_a;
    logic [alu_pkg::WIDTH-1:0] alu_b;
    logic [alu_pkg::OPW-1:0]   alu_op;
    logic [alu_pkg::WIDTH:0]   alu_result;

    modport master (output alu_a, output alu_b, output alu_op, input  alu_result);
    modport slave  (input  alu_a, input  alu_b, input  alu_op, output alu_result);
endinterface

// File: rtl/alu_vec_gen.sv
// Op/a/b vector counter: b fastest, then a, then the next enabled opcode.
module alu_vec_gen
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            adv_i,
    input  logic [NOPS-1:0] mask_i,
    output alu_vec_t        vec_o,
    output logic            last_vec_c
);

    logic [NOPS-1:0] mask_q;
    alu_vec_t        vec_q;
    alu_vec_t        vec_d;

    always_comb begin
        vec_d   = vec_q;
        vec_d.b = vec_q.b + WIDTH'(1);
        if (&vec_q.b) begin
            vec_d.a = vec_q.a + WIDTH'(1);
            if (&vec_q.a) vec_d.op = next_op(mask_q, vec_q.op);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            vec_q  <= '0;
        end else if (load_i) begin
            mask_q <= mask_i;
            vec_q  <= alu_vec_t'{op: first_op(mask_i), a: '0, b: '0};
        end else if (adv_i) begin
            vec_q <= vec_d;
        end
    end

    assign vec_o      = vec_q;
    assign last_vec_c = (&vec_q.a) & (&vec_q.b) & ~has_next(mask_q, vec_q.op);

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive ALU self-test: drives every enabled vector, compares against the model, logs the first miss.
module alu_sweep_checker
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NOPS-1:0]      op_mask,
    alu_sweep_checker_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [ERRW-1:0]      err_count,
    output logic                 err_valid,
    output logic [OPW-1:0]       err_op,
    output logic [WIDTH-1:0]     err_a,
    output logic [WIDTH-1:0]     err_b,
    output logic [WIDTH:0]       err_got
);

    sweep_state_e state_q, state_d;
    alu_vec_t     vec;
    logic         last_vec_c;
    logic         load_c;
    logic         adv_c;
    logic         accept_c;
    logic         check_c;
    logic         mismatch_c;

    logic            busy_q, done_q, err_valid_q;
    logic [ERRW-1:0] err_count_q;
    logic [OPW-1:0]  err_op_q;
    logic [WIDTH-1:0] err_a_q, err_b_q;
    logic [WIDTH:0]  err_got_q;

    alu_vec_gen u_vec_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_c),
        .adv_i      (adv_c),
        .mask_i     (op_mask),
        .vec_o      (vec),
        .last_vec_c (last_vec_c)
    );

    // Next-state and control strobes.
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        adv_c    = 1'b0;
        accept_c = 1'b0;
        check_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (|op_mask) begin
                        load_c  = 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRIVE: state_d = ST_CHECK;
            ST_CHECK: begin
                check_c = 1'b1;
                adv_c   = 1'b1;
                state_d = last_vec_c ? ST_DONE : ST_DRIVE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operands have been stable for a full cycle by the time CHECK samples the result.
    assign mismatch_c = (bus.alu_result != alu_model(vec.op, vec.a, vec.b));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            err_op_q    <= '0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            err_got_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_DRIVE) || (state_d == ST_CHECK);
            done_q  <= (state_d == ST_DONE);
            if (accept_c) begin
                err_count_q <= '0;
                err_valid_q <= 1'b0;
                err_op_q    <= '0;
                err_a_q     <= '0;
                err_b_q     <= '0;
                err_got_q   <= '0;
            end else if (check_c && mismatch_c) begin
                err_count_q <= err_count_q + ERRW'(1);
                if (!err_valid_q) begin
                    err_valid_q <= 1'b1;
                    err_op_q    <= vec.op;
                    err_a_q     <= vec.a;
                    err_b_q     <= vec.b;
                    err_got_q   <= bus.alu_result;
                end
            end
        end
    end

    assign bus.alu_a  = vec.a;
    assign bus.alu_b  = vec.b;
    assign bus.alu_op = vec.op;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign err_valid = err_valid_q;
    assign err_op    = err_op_q;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
    assign err_got   = err_got_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench for alu_sweep_checker with a behavioural ALU that can be made faulty on opcode 111.
module tb_alu_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op_mask = 8'h00;
    logic       fault_en = 1'b0;

    logic        busy, done, err_valid;
    logic [11:0] err_count;
    logic [2:0]  err_op;
    logic [3:0]  err_a, err_b;
    logic [4:0]  err_got;

    logic [7:0] seen_ops = 8'h00;
    int vectors = 0;
    int miscompares = 0;
    int lat;

    always #5 clk = ~clk;

    alu_sweep_checker_if bus ();

    alu_sweep_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_mask   (op_mask),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .err_valid (err_valid),
        .err_op    (err_op),
        .err_a     (err_a),
        .err_b     (err_b),
        .err_got   (err_got)
    );

    // Independent ALU written out by hand; opcode 111 can be stuck at zero.
    always_comb begin
        bus.alu_result = 5'd0;
        case (bus.alu_op)
            3'd0: bus.alu_result = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1: bus.alu_result = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'd2: bus.alu_result = {1'b0, bus.alu_a & bus.alu_b};
            3'd3: bus.alu_result = {1'b0, bus.alu_a | bus.alu_b};
            3'd4: bus.alu_result = {1'b0, bus.alu_a ^ bus.alu_b};
            3'd5: bus.alu_result = {1'b0, ~bus.alu_a};
            3'd6: bus.alu_result = {bus.alu_a, 1'b0};
            3'd7: bus.alu_result = fault_en ? 5'd0 : {2'b00, bus.alu_a[3:1]};
            default: bus.alu_result = 5'd0;
        endcase
    end

    always @(negedge clk) begin
        if (busy) seen_ops[bus.alu_op] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_a"},     32'(bus.alu_a),  0);
        check({tag, ".alu_b"},     32'(bus.alu_b),  0);
        check({tag, ".alu_op"},    32'(bus.alu_op), 0);
        check({tag, ".busy"},      32'(busy),       0);
        check({tag, ".done"},      32'(done),       0);
        check({tag, ".err_count"}, 32'(err_count),  0);
        check({tag, ".err_valid"}, 32'(err_valid),  0);
        check({tag, ".err_op"},    32'(err_op),     0);
        check({tag, ".err_a"},     32'(err_a),      0);
        check({tag, ".err_b"},     32'(err_b),      0);
        check({tag, ".err_got"},   32'(err_got),    0);
    endtask

    // Pulse start, then count negedges until done; lat = cycles from start to the done pulse.
    task automatic run_sweep(input logic [7:0] mask, output int l, output logic first_busy);
        @(negedge clk);
        op_mask = mask;
        start   = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_busy = busy;
        l = 1;
        while (!done && l < 6000) begin
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        logic fb;

        // Reset values
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Empty mask: done one cycle later, bus stays at zero
        run_sweep(8'h00, lat, fb);
        check("mask0.latency", 32'(lat), 1);
        check("mask0.busy", 32'(fb), 0);
        check("mask0.alu_a", 32'(bus.alu_a), 0);
        check("mask0.alu_op", 32'(bus.alu_op), 0);
        @(negedge clk);
        check("mask0.done_pulse", 32'(done), 0);

        // Golden ALU, all ops
        seen_ops = 8'h00;
        run_sweep(8'hFF, lat, fb);
        check("ff.latency", 32'(lat), 4097);
        check("ff.busy_after_start", 32'(fb), 1);
        check("ff.err_count", 32'(err_count), 0);
        check("ff.err_valid", 32'(err_valid), 0);
        check("ff.busy_in_done", 32'(busy), 0);
        check("ff.seen_ops", 32'(seen_ops), 32'hFF);
        @(negedge clk);
        check("ff.done_pulse", 32'(done), 0);

        // Opcode 111 stuck at zero: A in {0,1} gives 32 matching vectors, 224 misses
        fault_en = 1'b1;
        run_sweep(8'hFF, lat, fb);
        check("fault.latency", 32'(lat), 4097);
        check("fault.err_count", 32'(err_count), 224);
        check("fault.err_valid", 32'(err_valid), 1);
        check("fault.err_op", 32'(err_op), 7);
        check("fault.err_a", 32'(err_a), 2);
        check("fault.err_b", 32'(err_b), 0);
        check("fault.err_got", 32'(err_got), 0);
        fault_en = 1'b0;
        repeat (5) @(negedge clk);
        check("fault.hold_count", 32'(err_count), 224);
        check("fault.hold_a", 32'(err_a), 2);

        // Sparse mask: only ops 000 and 101
        seen_ops = 8'h00;
        run_sweep(8'b0010_0001, lat, fb);
        check("m21.latency", 32'(lat), 1025);
        check("m21.seen_ops", 32'(seen_ops), 32'h21);
        check("m21.err_count", 32'(err_count), 0);
        check("m21.err_valid", 32'(err_valid), 0);

        // Second start mid-sweep is ignored; mask change with it too
        @(negedge clk);
        op_mask = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        op_mask = 8'h01;
        lat = 1;
        while (!done && lat < 6000) begin
            @(negedge clk);
            lat++;
            start = (lat == 100);
        end
        start = 1'b0;
        check("restart.latency", 32'(lat), 4097);
        check("restart.err_count", 32'(err_count), 0);

        // Reset mid-sweep zeroes everything at once and the sweep does not resume
        fault_en = 1'b1;
        run_sweep(8'h80, lat, fb);
        check("prefill.err_count", 32'(err_count), 224);
        fault_en = 1'b0;
        @(negedge clk);
        op_mask = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (299) @(negedge clk);
        check("midrst.busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst.stays_idle", 32'(busy), 0);
        check("midrst.no_done", 32'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
